// File: rtl/psram_burst_ctrl_if.sv
// Request, write-pop, read-return and PSRAM pin bundle for psram_burst_ctrl.
// Handshake: a request moves only on a cycle where req_valid && req_ready; wr_ready pops the word on wr_data that cycle.
interface psram_burst_ctrl_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err_timeout;
    logic              ps_ce_n;
    logic              ps_adv_n;
    logic              ps_oe_n;
    logic              ps_we_n;
    logic [ADDR_W-1:0] ps_addr;
    logic [DATA_W-1:0] ps_dq_o;
    logic              ps_dq_oe;
    logic [DATA_W-1:0] ps_dq_i;
    logic              ps_wait_q;

    // Controller view: serves arbiter requests and drives the PSRAM pins.
    modport slave (
        input  req_valid, req_we, req_addr, wr_data, ps_dq_i, ps_wait_q,
        output req_ready, wr_ready, rd_data, rd_valid, done, err_timeout,
        output ps_ce_n, ps_adv_n, ps_oe_n, ps_we_n, ps_addr, ps_dq_o, ps_dq_oe
    );

    modport master (
        output req_valid, req_we, req_addr, wr_data, ps_dq_i, ps_wait_q,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err_timeout,
        input  ps_ce_n, ps_adv_n, ps_oe_n, ps_we_n, ps_addr, ps_dq_o, ps_dq_oe
    );
endinterface

// File: rtl/psram_burst_ctrl.sv
// Synchronous-burst PSRAM initiator: address cycle, fixed initial latency, WAIT-paced
// beats with a consecutive-WAIT timeout, and a chip-enable recovery cycle per burst.
module psram_burst_ctrl #(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int LAT_CYC   = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst,
    psram_burst_ctrl_if.slave  bus,
    output logic [2:0]         o_dbg_state
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_PRE  = BEAT_W'(BURST_LEN - 2);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [2:0]        LAT_LAST  = 3'(LAT_CYC - 1);
    localparam logic [2:0]        LAT_PRE   = 3'(LAT_CYC - 2);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LAT   = 3'd2,
        S_BURST = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_we;
    logic               r_abort;
    logic [2:0]         r_lat_cnt;
    logic [BEAT_W-1:0]  r_beat;
    logic [TO_W-1:0]    r_to_cnt;
    logic [DATA_W-1:0]  r_wbuf;
    logic               r_ce_n;
    logic               r_adv_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_dq_o;
    logic               r_dq_oe;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic               r_wr_ready;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic [DATA_W-1:0]  w_wr_word;

    assign bus.req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept      = bus.req_valid && bus.req_ready;
    // Next write word: the word being popped right now, else the one popped during a WAIT cycle.
    assign w_wr_word     = r_wr_ready ? bus.wr_data : r_wbuf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_abort    <= 1'b0;
            r_lat_cnt  <= '0;
            r_beat     <= '0;
            r_to_cnt   <= '0;
            r_wbuf     <= '0;
            r_ce_n     <= 1'b1;
            r_adv_n    <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_addr     <= '0;
            r_dq_o     <= '0;
            r_dq_oe    <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_abort <= 1'b0;
                        r_addr  <= bus.req_addr;
                        r_ce_n  <= 1'b0;
                        r_adv_n <= 1'b0;
                        r_we_n  <= ~bus.req_we;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_adv_n   <= 1'b1;
                    r_we_n    <= 1'b1;
                    r_lat_cnt <= '0;
                    if (LAT_CYC == 1) begin
                        r_oe_n     <= r_we;
                        r_wr_ready <= r_we;
                    end
                    r_state   <= S_LAT;
                end
                S_LAT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_beat   <= '0;
                        r_to_cnt <= '0;
                        if (r_we) begin
                            r_dq_oe    <= 1'b1;
                            r_dq_o     <= bus.wr_data;
                            r_wr_ready <= 1'b1;
                        end
                        r_state  <= S_BURST;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                        if (r_lat_cnt == LAT_PRE) begin
                            r_oe_n     <= r_we;
                            r_wr_ready <= r_we;
                        end
                    end
                end
                S_BURST: begin
                    if (!bus.ps_wait_q) begin
                        r_to_cnt <= '0;
                        r_beat   <= r_beat + BEAT_ONE;
                        if (!r_we) begin
                            r_rd_data  <= bus.ps_dq_i;
                            r_rd_valid <= 1'b1;
                        end else if (r_beat != BEAT_LAST) begin
                            r_dq_o     <= w_wr_word;
                            r_wr_ready <= (r_beat < BEAT_PRE);
                        end
                        if (r_beat == BEAT_LAST) begin
                            r_ce_n  <= 1'b1;
                            r_oe_n  <= 1'b1;
                            r_dq_oe <= 1'b0;
                            r_state <= S_END;
                        end
                    end else begin
                        if (r_wr_ready) begin
                            r_wbuf <= bus.wr_data;
                        end
                        if (r_to_cnt == TO_LAST) begin
                            r_abort <= 1'b1;
                            r_ce_n  <= 1'b1;
                            r_oe_n  <= 1'b1;
                            r_dq_oe <= 1'b0;
                            r_state <= S_END;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_ONE;
                        end
                    end
                end
                S_END: begin
                    r_done  <= 1'b1;
                    r_err   <= r_abort;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ps_ce_n     = r_ce_n;
    assign bus.ps_adv_n    = r_adv_n;
    assign bus.ps_oe_n     = r_oe_n;
    assign bus.ps_we_n     = r_we_n;
    assign bus.ps_addr     = r_addr;
    assign bus.ps_dq_o     = r_dq_o;
    assign bus.ps_dq_oe    = r_dq_oe;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.wr_ready    = r_wr_ready;
    assign bus.done        = r_done;
    assign bus.err_timeout = r_err;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_psram_burst_ctrl.sv
// Self-checking bench for psram_burst_ctrl: per-burst expectations are derived from the
// WAIT schedule (beat cycles, timeout run, end/done cycles) and compared cycle by cycle.
module tb_psram_burst_ctrl;
    localparam int ADDR_W    = 23;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 4;
    localparam int LAT_CYC   = 3;
    localparam int TIMEOUT   = 64;
    localparam int B0        = LAT_CYC + 2;   // offset of the first BURST cycle after the accept cycle
    localparam int NSCHED    = 256;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         n_checks;
    int         n_fail;

    psram_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    psram_burst_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .LAT_CYC(LAT_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.wr_data   = DATA_W'($urandom);
        bus.ps_dq_i   = DATA_W'($urandom);
        bus.ps_wait_q = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ce_n"},     bus.ps_ce_n, 1);
        check({pfx, "_adv_n"},    bus.ps_adv_n, 1);
        check({pfx, "_oe_n"},     bus.ps_oe_n, 1);
        check({pfx, "_we_n"},     bus.ps_we_n, 1);
        check({pfx, "_dq_oe"},    bus.ps_dq_oe, 0);
        check({pfx, "_addr"},     bus.ps_addr, 0);
        check({pfx, "_dq_o"},     bus.ps_dq_o, 0);
        check({pfx, "_rd_data"},  bus.rd_data, 0);
        check({pfx, "_rd_valid"}, bus.rd_valid, 0);
        check({pfx, "_done"},     bus.done, 0);
        check({pfx, "_err"},      bus.err_timeout, 0);
        check({pfx, "_wr_ready"}, bus.wr_ready, 0);
        check({pfx, "_req_ready"}, bus.req_ready, 0);
    endtask

    // kind: 0 no waits, 1 random waits, 2 two WAIT cycles after beat1, 3 WAIT stuck high
    task automatic run_burst(input logic we, input logic [ADDR_W-1:0] addr, input int kind,
                             input bit fixed_words);
        logic              w_sched[NSCHED];
        logic [DATA_W-1:0] dq[NSCHED];
        logic [DATA_W-1:0] words[BURST_LEN];
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] wq[$];
        int beat_off[BURST_LEN];
        int beats, run, end_off, kr, kw, pops, wen_low;
        bit abort;
        bit exp_rd;

        for (int i = 0; i < NSCHED; i++) begin
            dq[i] = DATA_W'($urandom);
            if (i < B0)          w_sched[i] = 1'($urandom_range(0, 1));
            else if (kind == 0)  w_sched[i] = 1'b0;
            else if (kind == 1)  w_sched[i] = ($urandom_range(0, 3) == 0);
            else if (kind == 2)  w_sched[i] = (i - B0 == 2) || (i - B0 == 3);
            else                 w_sched[i] = 1'b1;
        end
        for (int k = 0; k < BURST_LEN; k++) begin
            words[k] = fixed_words ? DATA_W'(16'h1111 * (k + 1)) : DATA_W'($urandom);
            if (we) wq.push_back(words[k]);
        end

        // Reference: walk the WAIT schedule from the first BURST cycle.
        beats = 0; run = 0; end_off = -1; abort = 0;
        for (int j = 0; (B0 + j < NSCHED) && (end_off < 0); j++) begin
            if (!w_sched[B0 + j]) begin
                beat_off[beats] = B0 + j;
                if (!we) exp_q.push_back(dq[B0 + j]);
                beats++;
                run = 0;
                if (beats == BURST_LEN) end_off = B0 + j + 1;
            end else begin
                run++;
                if (run == TIMEOUT) begin
                    end_off = B0 + j + 1;
                    abort = 1;
                end
            end
        end

        kr = 0; kw = 0; pops = 0; wen_low = 0;
        for (int off = 0; off <= end_off + 1; off++) begin
            @(negedge clk);
            if (off == 0)            check("req_ready_idle", bus.req_ready, 1);
            else if (off <= end_off) check("req_ready_busy", bus.req_ready, 0);
            else                     check("req_ready_back", bus.req_ready, 1);
            if (off == 1) begin
                check("addr_cyc_adv_n", bus.ps_adv_n, 0);
                check("addr_cyc_ce_n", bus.ps_ce_n, 0);
                check("addr_cyc_addr", bus.ps_addr, addr);
                check("addr_cyc_we_n", bus.ps_we_n, !we);
            end else if (off > 1 && off < end_off) begin
                check("active_ce_n", bus.ps_ce_n, 0);
                check("active_adv_n", bus.ps_adv_n, 1);
            end
            if (off > 0 && bus.ps_we_n == 1'b0) wen_low++;

            exp_rd = !we && (kr < beats) && (off == beat_off[kr] + 1);
            check("rd_valid", bus.rd_valid, exp_rd);
            if (exp_rd) begin
                check("rd_data", bus.rd_data, exp_q.pop_front());
                kr++;
            end
            check("done", bus.done, off == end_off + 1);
            check("err_timeout", bus.err_timeout, (off == end_off + 1) && abort);
            if (off >= end_off) begin
                check("end_ce_n", bus.ps_ce_n, 1);
                check("end_dq_oe", bus.ps_dq_oe, 0);
            end
            if (we) begin
                check("wr_oe_n", bus.ps_oe_n, 1);
                if (off >= B0 && off < end_off) check("wr_dq_oe", bus.ps_dq_oe, 1);
                if (kw < beats && off == beat_off[kw]) begin
                    check("wr_dq_o", bus.ps_dq_o, words[kw]);
                    kw++;
                end
            end else begin
                check("rd_dq_oe", bus.ps_dq_oe, 0);
                if (off >= B0 && off < end_off) check("rd_oe_n", bus.ps_oe_n, 0);
            end
            if (bus.wr_ready) pops++;

            bus.req_valid = (off == 0);
            bus.req_we    = we;
            bus.req_addr  = addr;
            bus.ps_wait_q = w_sched[off];
            bus.ps_dq_i   = dq[off];
            bus.wr_data   = (wq.size() > 0) ? wq[0] : DATA_W'($urandom);
            if (bus.wr_ready && wq.size() > 0) void'(wq.pop_front());
        end
        check("we_n_low_cycles", wen_low, we ? 1 : 0);
        if (we && !abort) begin
            check("wr_ready_pulses", pops, BURST_LEN);
            check("wr_fifo_drained", wq.size(), 0);
        end
        if (!we) check("rd_count", kr, abort ? 0 : BURST_LEN);
    endtask

    task automatic reset_mid_burst();
        for (int off = 0; off <= B0 + 2; off++) begin
            @(negedge clk);
            bus.req_valid = (off == 0);
            bus.req_we    = 1'b0;
            bus.req_addr  = ADDR_W'($urandom);
            bus.ps_wait_q = (off >= B0) ? 1'b0 : 1'b1;
            bus.ps_dq_i   = DATA_W'($urandom);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_req_ready", bus.req_ready, 1);
            check("post_rst_done", bus.done, 0);
            check("post_rst_rd_valid", bus.rd_valid, 0);
            drive_idle();
        end
    endtask

    task automatic back_to_back();
        logic ce_h[60];
        int accepts, dones, rvs, i1, h0, l2;
        accepts = 0; dones = 0; rvs = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ce_h[c] = bus.ps_ce_n;
            if (bus.done) dones++;
            if (bus.rd_valid) rvs++;
            bus.req_valid = (accepts < 2);
            bus.req_we    = 1'b0;
            bus.req_addr  = ADDR_W'($urandom);
            bus.ps_wait_q = 1'b0;
            bus.ps_dq_i   = DATA_W'($urandom);
            if (bus.req_valid && bus.req_ready) accepts++;
        end
        i1 = -1; h0 = -1; l2 = -1;
        for (int c = 0; c < 60; c++) begin
            if (i1 < 0 && !ce_h[c]) i1 = c;
            else if (i1 >= 0 && h0 < 0 && ce_h[c]) h0 = c;
            else if (h0 >= 0 && l2 < 0 && !ce_h[c]) l2 = c;
        end
        check("b2b_accepts", accepts, 2);
        check("b2b_dones", dones, 2);
        check("b2b_rd_valids", rvs, 2 * BURST_LEN);
        check("b2b_ce_gap", (h0 >= 0 && l2 >= 0) ? (l2 - h0) : -1, 2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1);

        run_burst(1'b0, 23'h012345, 0, 1'b0);
        run_burst(1'b0, ADDR_W'($urandom), 2, 1'b0);
        run_burst(1'b1, ADDR_W'($urandom), 0, 1'b1);
        run_burst(1'b0, ADDR_W'($urandom), 3, 1'b0);
        run_burst(1'b1, ADDR_W'($urandom), 2, 1'b0);
        reset_mid_burst();
        back_to_back();
        drive_idle();
        repeat (3) @(negedge clk);
        drive_idle();
        for (int n = 0; n < 30; n++) begin
            run_burst(1'($urandom_range(0, 1)), ADDR_W'($urandom),
                      $urandom_range(0, 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
